// File: rtl/reservation_station.sv
// Reservation station: collapsing queue of dispatched instructions, CDB operand snooping, oldest-ready-first issue.
// Optional RS_WAKEUP_ISSUE_EN: an operand matching the current CDB broadcast counts as ready in the same cycle.
module reservation_station #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             dispatch_valid,
    output logic             dispatch_ready,
    input  logic [2:0]       d_Unit,
    input  logic [9:0]       d_Op,
    input  logic [31:0]      d_pc,
    input  logic [31:0]      d_rdm,
    input  logic [31:0]      d_Vj,
    input  logic [31:0]      d_Vk,
    input  logic [TAG_W-1:0] d_Qj,
    input  logic [TAG_W-1:0] d_Qk,
    input  logic             d_Qj_busy,
    input  logic             d_Qk_busy,
    input  logic [TAG_W-1:0] d_dest,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [2:0]       i_Unit,
    output logic [9:0]       i_Op,
    output logic [31:0]      i_pc,
    output logic [31:0]      i_rdm,
    output logic [31:0]      i_Vj,
    output logic [31:0]      i_Vk,
    output logic [TAG_W-1:0] i_dest
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [2:0]       unit;
        logic [9:0]       op;
        logic [31:0]      pc;
        logic [31:0]      rdm;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic [TAG_W-1:0] dest;
        logic             qj_busy;
        logic             qk_busy;
    } entry_t;

    entry_t          slots [DEPTH];
    entry_t          woken [DEPTH];
    entry_t          nxt   [DEPTH];
    entry_t          d_entry;
    entry_t          sel_entry;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic [CW-1:0]   wr;
    logic [DEPTH-1:0] ready;
    logic [IW-1:0]   sel;
    logic            found;
    logic            do_issue;
    logic            do_disp;

    function automatic entry_t wake(input entry_t e, input logic v,
                                    input logic [TAG_W-1:0] t, input logic [31:0] val);
        entry_t r;
        r = e;
        if (v && e.qj_busy && e.qj == t) begin
            r.vj      = val;
            r.qj_busy = 1'b0;
        end
        if (v && e.qk_busy && e.qk == t) begin
            r.vk      = val;
            r.qk_busy = 1'b0;
        end
        return r;
    endfunction

    always_comb begin
        ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_WAKEUP_ISSUE_EN
            ready[i] = (CW'(i) < count)
                     && (!slots[i].qj_busy || (cdb_valid && slots[i].qj == cdb_tag))
                     && (!slots[i].qk_busy || (cdb_valid && slots[i].qk == cdb_tag));
`else
            ready[i] = (CW'(i) < count) && !slots[i].qj_busy && !slots[i].qk_busy;
`endif
        end
    end

    // Descending scan so the lowest ready index is the last one written.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel   = IW'(i);
                found = 1'b1;
            end
        end
    end

    assign sel_entry      = slots[sel];
    assign dispatch_ready = (count < CW'(DEPTH));
    assign do_issue       = found & issue_ready;
    assign do_disp        = dispatch_valid & dispatch_ready;

    always_comb begin
        issue_valid = found;
        i_Unit      = '0;
        i_Op        = '0;
        i_pc        = '0;
        i_rdm       = '0;
        i_Vj        = '0;
        i_Vk        = '0;
        i_dest      = '0;
        if (found) begin
            i_Unit = sel_entry.unit;
            i_Op   = sel_entry.op;
            i_pc   = sel_entry.pc;
            i_rdm  = sel_entry.rdm;
            i_Vj   = sel_entry.vj;
            i_Vk   = sel_entry.vk;
            i_dest = sel_entry.dest;
`ifdef RS_WAKEUP_ISSUE_EN
            if (sel_entry.qj_busy) i_Vj = cdb_value;
            if (sel_entry.qk_busy) i_Vk = cdb_value;
`endif
        end
    end

    always_comb begin
        d_entry = '{unit: d_Unit, op: d_Op, pc: d_pc, rdm: d_rdm, vj: d_Vj, vk: d_Vk,
                    qj: d_Qj, qk: d_Qk, dest: d_dest, qj_busy: d_Qj_busy, qk_busy: d_Qk_busy};
        wr = do_issue ? count - CW'(1) : count;
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = wake(slots[i], cdb_valid, cdb_tag, cdb_value);
            nxt[i]   = woken[i];
        end
        // Collapse: slots above the issued one move down by one.
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (do_issue && IW'(i) >= sel) nxt[i] = woken[i + 1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (do_disp && CW'(i) == wr) nxt[i] = wake(d_entry, cdb_valid, cdb_tag, cdb_value);
        end
        case ({do_disp, do_issue})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count_nxt;
            for (int i = 0; i < DEPTH; i++) slots[i] <= nxt[i];
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: queue-based reference model checked every cycle plus directed literal checks.
module tb_reservation_station;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset, flush, dispatch_valid, dispatch_ready;
    logic [2:0]       d_Unit;
    logic [9:0]       d_Op;
    logic [31:0]      d_pc, d_rdm, d_Vj, d_Vk;
    logic [TAG_W-1:0] d_Qj, d_Qk, d_dest;
    logic             d_Qj_busy, d_Qk_busy;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    logic             issue_valid, issue_ready;
    logic [2:0]       i_Unit;
    logic [9:0]       i_Op;
    logic [31:0]      i_pc, i_rdm, i_Vj, i_Vk;
    logic [TAG_W-1:0] i_dest;

    reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .d_Unit(d_Unit), .d_Op(d_Op), .d_pc(d_pc), .d_rdm(d_rdm),
        .d_Vj(d_Vj), .d_Vk(d_Vk), .d_Qj(d_Qj), .d_Qk(d_Qk),
        .d_Qj_busy(d_Qj_busy), .d_Qk_busy(d_Qk_busy), .d_dest(d_dest),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .i_Unit(i_Unit), .i_Op(i_Op), .i_pc(i_pc), .i_rdm(i_rdm),
        .i_Vj(i_Vj), .i_Vk(i_Vk), .i_dest(i_dest)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       unit;
        logic [9:0]       op;
        logic [31:0]      pc, rdm, vj, vk;
        logic [TAG_W-1:0] qj, qk, dest;
        logic             jb, kb;
    } ent_t;

    ent_t m_q[$];
    ent_t m_e;
    int   ms;
    int   total = 0;
    int   bad   = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t wake(input ent_t e);
        ent_t r = e;
        if (cdb_valid && e.jb && e.qj == cdb_tag) begin r.vj = cdb_value; r.jb = 1'b0; end
        if (cdb_valid && e.kb && e.qk == cdb_tag) begin r.vk = cdb_value; r.kb = 1'b0; end
        return r;
    endfunction

    function automatic bit avail(input logic busy, input logic [TAG_W-1:0] tag);
`ifdef RS_WAKEUP_ISSUE_EN
        return !busy || (cdb_valid && tag == cdb_tag);
`else
        return !busy || (tag != tag);
`endif
    endfunction

    function automatic int model_sel();
        for (int i = 0; i < m_q.size(); i++)
            if (avail(m_q[i].jb, m_q[i].qj) && avail(m_q[i].kb, m_q[i].qk)) return i;
        return -1;
    endfunction

    // Reference model update: oldest-first queue, wakeup, remove issued, append dispatched.
    always @(posedge clk) begin : model_upd
        int   s;
        bit   iss, dsp;
        ent_t ne;
        if (reset || flush) begin
            m_q.delete();
        end else begin
            s   = model_sel();
            iss = (s >= 0) && issue_ready;
            dsp = dispatch_valid && (m_q.size() < DEPTH);
            foreach (m_q[k]) m_q[k] = wake(m_q[k]);
            if (iss) m_q.delete(s);
            if (dsp) begin
                ne = '{unit: d_Unit, op: d_Op, pc: d_pc, rdm: d_rdm, vj: d_Vj, vk: d_Vk,
                       qj: d_Qj, qk: d_Qk, dest: d_dest, jb: d_Qj_busy, kb: d_Qk_busy};
                m_q.push_back(wake(ne));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            ms = model_sel();
            m_e = '0;
            if (ms >= 0) begin
                m_e = m_q[ms];
                if (m_e.jb) m_e.vj = cdb_value;
                if (m_e.kb) m_e.vk = cdb_value;
            end
            chk("m_dready", 32'(dispatch_ready), 32'(m_q.size() < DEPTH));
            chk("m_valid",  32'(issue_valid),    32'(ms >= 0));
            chk("m_unit",   32'(i_Unit),         32'(m_e.unit));
            chk("m_op",     32'(i_Op),           32'(m_e.op));
            chk("m_pc",     i_pc,                m_e.pc);
            chk("m_rdm",    i_rdm,               m_e.rdm);
            chk("m_vj",     i_Vj,                m_e.vj);
            chk("m_vk",     i_Vk,                m_e.vk);
            chk("m_dest",   32'(i_dest),         32'(m_e.dest));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [31:0] pc, input logic [31:0] vj, input logic jb,
                         input logic [TAG_W-1:0] qj, input logic [31:0] vk, input logic kb,
                         input logic [TAG_W-1:0] qk);
        d_pc = pc; d_Unit = 3'((pc >> 8) % 5); d_Op = pc[11:2]; d_rdm = ~pc;
        d_Vj = vj; d_Qj_busy = jb; d_Qj = qj;
        d_Vk = vk; d_Qk_busy = kb; d_Qk = qk;
        d_dest = pc[5:2];
        dispatch_valid = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; dispatch_valid = 1'b0; issue_ready = 1'b0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        set_d(32'h0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        dispatch_valid = 1'b0;
        tick(); tick();
        reset = 1'b0; chk_en = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(issue_valid), 32'd0);
        chk("rst_dready", 32'(dispatch_ready), 32'd1);
        chk("rst_pc", i_pc, 32'd0);

        // Both operands ready: visible the cycle after dispatch.
        tick(); set_d(32'h100, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0);
        @(negedge clk); chk("t1_pre_valid", 32'(issue_valid), 32'd0);
        tick(); dispatch_valid = 1'b0; issue_ready = 1'b1;
        @(negedge clk);
        chk("t1_valid", 32'(issue_valid), 32'd1);
        chk("t1_vj", i_Vj, 32'd5);
        chk("t1_vk", i_Vk, 32'd7);
        chk("t1_pc", i_pc, 32'h100);
        tick(); issue_ready = 1'b0;
        @(negedge clk); chk("t1_empty", 32'(issue_valid), 32'd0);

        // Stored entry waits for tag 3.
        tick(); set_d(32'h200, 32'h0, 1'b1, 4'd3, 32'd9, 1'b0, 4'd0);
        tick(); dispatch_valid = 1'b0;
        @(negedge clk); chk("t2_wait", 32'(issue_valid), 32'd0);
        tick(); cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_value = 32'h100;
        @(negedge clk);
`ifdef RS_WAKEUP_ISSUE_EN
        chk("t2_cdb_valid", 32'(issue_valid), 32'd1);
        chk("t2_cdb_vj", i_Vj, 32'h100);
`else
        chk("t2_cdb_valid", 32'(issue_valid), 32'd0);
`endif
        tick(); cdb_valid = 1'b0; issue_ready = 1'b1;
        @(negedge clk);
        chk("t2_valid", 32'(issue_valid), 32'd1);
        chk("t2_vj", i_Vj, 32'h100);
        chk("t2_vk", i_Vk, 32'd9);
        tick(); issue_ready = 1'b0;
        @(negedge clk); chk("t2_empty", 32'(issue_valid), 32'd0);

        // Broadcast coincides with dispatch.
        tick(); set_d(32'h300, 32'd1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd6);
        cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_value = 32'd42;
        @(negedge clk); chk("t3_pre_valid", 32'(issue_valid), 32'd0);
        tick(); dispatch_valid = 1'b0; cdb_valid = 1'b0; issue_ready = 1'b1;
        @(negedge clk);
        chk("t3_valid", 32'(issue_valid), 32'd1);
        chk("t3_vk", i_Vk, 32'd42);
        chk("t3_pc", i_pc, 32'h300);
        tick(); issue_ready = 1'b0;
        @(negedge clk); chk("t3_empty", 32'(issue_valid), 32'd0);

        // Oldest waits on tag 1, younger entries are ready.
        tick(); set_d(32'h400, 32'h0, 1'b1, 4'd1, 32'd2, 1'b0, 4'd0);
        tick(); set_d(32'h404, 32'd4, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0);
        tick(); set_d(32'h408, 32'd8, 1'b0, 4'd0, 32'd8, 1'b0, 4'd0);
        tick(); set_d(32'h40c, 32'd12, 1'b0, 4'd0, 32'd12, 1'b0, 4'd0);
        tick(); dispatch_valid = 1'b0;
        @(negedge clk);
        chk("t4_full", 32'(dispatch_ready), 32'd0);
        chk("t4_sel", i_pc, 32'h404);
        tick(); issue_ready = 1'b1;
        @(negedge clk); chk("t4_iss0", i_pc, 32'h404);
        tick();
        @(negedge clk); chk("t4_iss1", i_pc, 32'h408); chk("t4_dready", 32'(dispatch_ready), 32'd1);
        tick();
        @(negedge clk); chk("t4_iss2", i_pc, 32'h40c);
        tick();
        @(negedge clk); chk("t4_blocked", 32'(issue_valid), 32'd0);
        tick(); cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_value = 32'h55;
        @(negedge clk);
`ifdef RS_WAKEUP_ISSUE_EN
        chk("t4_cdb_pc", i_pc, 32'h400);
        chk("t4_cdb_vj", i_Vj, 32'h55);
`else
        chk("t4_cdb_valid", 32'(issue_valid), 32'd0);
`endif
        tick(); cdb_valid = 1'b0;
        @(negedge clk);
`ifdef RS_WAKEUP_ISSUE_EN
        chk("t4_after_valid", 32'(issue_valid), 32'd0);
`else
        chk("t4_late_pc", i_pc, 32'h400);
        chk("t4_late_vj", i_Vj, 32'h55);
`endif
        tick(); issue_ready = 1'b0;
        @(negedge clk); chk("t4_empty", 32'(issue_valid), 32'd0);

        // Full with simultaneous issue: dispatch waits a cycle.
        tick(); set_d(32'h500, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0);
        tick(); set_d(32'h504, 32'd2, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0);
        tick(); set_d(32'h508, 32'd3, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0);
        tick(); set_d(32'h50c, 32'd4, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0);
        tick(); set_d(32'h510, 32'd5, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0); issue_ready = 1'b1;
        @(negedge clk); chk("t5_full", 32'(dispatch_ready), 32'd0); chk("t5_pc0", i_pc, 32'h500);
        tick(); issue_ready = 1'b0;
        @(negedge clk); chk("t5_three", 32'(dispatch_ready), 32'd1); chk("t5_pc1", i_pc, 32'h504);
        tick(); dispatch_valid = 1'b0;
        @(negedge clk); chk("t5_refull", 32'(dispatch_ready), 32'd0);
        tick(); issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); chk("t5_drain", i_pc, 32'h504 + 32'(4 * k));
            tick();
        end
        issue_ready = 1'b0;
        @(negedge clk); chk("t5_empty", 32'(issue_valid), 32'd0);

        // Flush overrides dispatch and CDB.
        tick(); set_d(32'h600, 32'd6, 1'b0, 4'd0, 32'd6, 1'b0, 4'd0);
        tick(); set_d(32'h604, 32'h0, 1'b1, 4'd7, 32'd6, 1'b0, 4'd0);
        tick(); set_d(32'h608, 32'd6, 1'b0, 4'd0, 32'h0, 1'b1, 4'd8);
        tick(); set_d(32'h60c, 32'd6, 1'b0, 4'd0, 32'd6, 1'b0, 4'd0);
        flush = 1'b1; cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_value = 32'h77;
        @(negedge clk); chk("t6_preflush", i_pc, 32'h600);
        tick(); flush = 1'b0; dispatch_valid = 1'b0; cdb_tag = 4'd8; cdb_value = 32'h88; issue_ready = 1'b1;
        @(negedge clk);
        chk("t6_valid", 32'(issue_valid), 32'd0);
        chk("t6_dready", 32'(dispatch_ready), 32'd1);
        tick(); cdb_valid = 1'b0;
        @(negedge clk); chk("t6_stale", 32'(issue_valid), 32'd0);
        tick(); issue_ready = 1'b0;

        // Reset mid-operation drops the entry.
        set_d(32'h700, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0);
        tick(); dispatch_valid = 1'b0; reset = 1'b1;
        @(negedge clk); chk("t7_held", i_pc, 32'h700);
        tick(); reset = 1'b0;
        @(negedge clk); chk("t7_dropped", 32'(issue_valid), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Issue-side producer for the execute stage: holds dispatched instructions until both source operands are available, then presents one ready instruction per cycle.
- Presented fields: Unit, Op, pc, rdm, Vj, Vk.
- Captures missing operands by snooping the common data bus (CDB) on tag match.
- Oldest-ready-first selection; sits between decode/rename dispatch and the ex stage.

Parameters:
- DEPTH, 4, number of entries (2..16).
- TAG_W, 4, width of operand/destination tags (ROB index).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- flush  input  1  clear all entries (branch mispredict)
- dispatch_valid  input  1  dispatch request
- dispatch_ready  output  1  entry free (count < DEPTH)
- d_Unit  input  unit  target unit (ALU/BRANCH/MUL/DIV/LOAD)
- d_Op  input  10  opcode bundle
- d_pc  input  32  instruction pc
- d_rdm  input  32  load data field, passed through unchanged
- d_Vj, d_Vk  input  32  operand values when available
- d_Qj, d_Qk  input  TAG_W  producer tags
- d_Qj_busy, d_Qk_busy  input  1  operand pending (value not yet valid)
- d_dest  input  TAG_W  destination tag
- cdb_valid  input  1  CDB broadcast valid
- cdb_tag  input  TAG_W  broadcast tag
- cdb_value  input  32  broadcast value
- issue_valid  output  1  a ready entry is presented
- issue_ready  input  1  ex accepts this cycle
- i_Unit  output  unit  issued unit
- i_Op  output  10  issued opcode
- i_pc, i_rdm, i_Vj, i_Vk  output  32  issued fields
- i_dest  output  TAG_W  issued destination tag

Behaviour:
- Storage is a collapsing queue: slots 0..count-1 valid, slot 0 oldest. Each slot holds all d_* fields plus Qj_busy/Qk_busy.
- Reset: count=0, all busy flags 0, dispatch_ready=1, issue_valid=0, all i_* outputs 0.
- flush: count=0 next cycle. Overrides dispatch, issue and CDB the same cycle. issue_valid still reflects pre-flush state during the flush cycle; ex ignores it.
- dispatch_ready = (count < DEPTH), from registered count only. A same-cycle issue does not free a slot for dispatch.
- Dispatch accepted when dispatch_valid & dispatch_ready. The entry is written at slot count, or count-1 if an issue also occurs that cycle.
- Wakeup of a stored entry: for each slot with Qj_busy & Qj==cdb_tag & cdb_valid, store Vj=cdb_value and clear Qj_busy next cycle. Same rule for k.
- Wakeup of a dispatching entry: the same compare is applied to d_Qj/d_Qk, so a broadcast coinciding with dispatch is never lost.
- Ready(slot) = valid & !Qj_busy & !Qk_busy, computed from registered state.
- Selection: lowest-index ready slot. issue_valid = any ready. i_* are combinational from the selected slot and all 0 when issue_valid=0.
- Issue handshake: issue_valid & issue_ready removes the selected slot. Slots above it shift down by one; count decrements, unless a dispatch occurs that cycle, in which case count is unchanged.
- Latency: a dispatch with both operands ready at cycle N gives issue_valid at N+1.
- CDB wakeup at cycle N gives issue eligibility at N+1 (without the optional feature).
- issue_ready low: the selection may change if an older entry becomes ready; no ordering guarantee beyond oldest-ready-first.
- CDB tags are unique among in-flight producers. Duplicate matches across slots all capture.
- Reset or flush mid-operation drops all entries; nothing is issued from dropped entries.

Optional Feature:
- RS_WAKEUP_ISSUE_EN defined: Ready also counts an operand as available when its busy flag is set and its tag matches the current CDB broadcast. The issued i_Vj/i_Vk take cdb_value in that case, giving back-to-back wakeup-to-issue (CDB at N, issue at N).
- Stored-entry capture is unchanged. The dispatching entry is excluded, since it is not yet stored.
- Not defined: behaviour exactly as in Behaviour (issue at N+1).

Test Plan:
- Reset, then dispatch ALU op with Vj=5, Vk=7, both not busy at cycle 1 -> issue_valid=1 at cycle 2 with i_Vj=5, i_Vk=7; issue_ready=1 -> count returns to 0.
- Dispatch entry with Qj=3 busy, Vk=9 ready; CDB tag 3 value 0x100 at cycle 4 -> issue_valid at cycle 5, i_Vj=0x100 (cycle 4 with RS_WAKEUP_ISSUE_EN).
- Dispatch with d_Qk=6 busy while cdb_valid, cdb_tag=6, cdb_value=42 in the same cycle -> entry stored ready; issues next cycle with i_Vk=42.
- Fill 4 entries: slot 0 waiting on tag 1, slots 1-3 ready, issue_ready held 0 -> dispatch_ready=0 and i_pc=slot 1's pc; then issue_ready=1 -> slots 1, 2, 3 issue in order, then slot 0 after CDB tag 1.
- Full RS with simultaneous issue and dispatch_valid -> dispatch not accepted that cycle, accepted next cycle; count goes 4 -> 3 -> 4.
- Three entries present, flush=1 together with dispatch_valid=1 and a matching CDB -> count=0, issue_valid=0 next cycle; no stale entry later issues.
